axi_rd_arbiter: RTL and testbench

Shares the single AXI read channel (AR/R) between the instruction-cache refill/uncached-fetch port and the data-cache refill/uncached-load port. Sits between both cache controllers and the AXI bridge. One read transaction is outstanding at a time. Each transaction is either a full cache-line burst or a single uncached word, and its returned beats are routed back to the owning requester.

---
 rtl/axi_rd_arbiter_pkg.sv | 20 ++
 rtl/axi_rd_arb_pick.sv | 42 ++++
 rtl/axi_rd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: FSM encoding, AXI constants,
// request-type encoding and default transaction IDs.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic RD_TYPE_WORD = 1'b0;
   localparam logic RD_TYPE_LINE = 1'b1;

   localparam logic [3:0] DEF_IC_ID = 4'd0;
   localparam logic [3:0] DEF_DC_ID = 4'd1;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Grant selector for the icache/dcache read ports. Macro AXI_RD_ARB_RR_EN selects
// round-robin (with a last-owner register); otherwise fixed dcache-over-icache priority.
module axi_rd_arb_pick (
`ifdef AXI_RD_ARB_RR_EN
   input  logic clk,
   input  logic resetn,
`endif
   input  logic en_i,
   input  logic ic_req_i,
   input  logic dc_req_i,
   output logic ic_gnt_o,
   output logic dc_gnt_o
);

`ifdef AXI_RD_ARB_RR_EN
   logic last_dc_q, last_dc_d;

   // On a tie the requester that was not granted most recently wins.
   always_comb begin
      dc_gnt_o  = en_i & dc_req_i & (~ic_req_i | ~last_dc_q);
      ic_gnt_o  = en_i & ic_req_i & ~dc_gnt_o;
      last_dc_d = last_dc_q;
      if (ic_gnt_o | dc_gnt_o) begin
         last_dc_d = dc_gnt_o;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_dc_q <= 1'b1;
      end else begin
         last_dc_q <= last_dc_d;
      end
   end
`else
   always_comb begin
      dc_gnt_o = en_i & dc_req_i;
      ic_gnt_o = en_i & ic_req_i & ~dc_req_i;
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI read arbiter between icache and dcache ports; routes R beats
// back to the owner and flags ID/RLAST protocol errors. Optional macro: AXI_RD_ARB_RR_EN.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [3:0]  IC_ID      = DEF_IC_ID,
   parameter logic [3:0]  DC_ID      = DEF_DC_ID
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ic_rd_req,
   input  logic        ic_rd_type,
   input  logic [31:0] ic_rd_addr,
   output logic        ic_rd_rdy,
   output logic        ic_ret_valid,
   output logic        ic_ret_last,
   output logic [31:0] ic_ret_data,
   input  logic        dc_rd_req,
   input  logic        dc_rd_type,
   input  logic [31:0] dc_rd_addr,
   output logic        dc_rd_rdy,
   output logic        dc_ret_valid,
   output logic        dc_ret_last,
   output logic [31:0] dc_ret_data,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        rd_err,
   output logic [1:0]  dbg_state
);

   localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
   localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

   arb_state_e  state_q, state_d;
   logic        owner_dc_q, owner_dc_d;
   logic [3:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  beat_q, beat_d;
   logic        err_q, err_d;

   logic        ic_gnt, dc_gnt, pick_en;
   logic        sel_type;
   logic [31:0] sel_addr;
   logic        beat_last;

   // Grants are gated by resetn so no rdy escapes while reset is held.
   assign pick_en = (state_q == ST_IDLE) & resetn;

   axi_rd_arb_pick u_pick (
`ifdef AXI_RD_ARB_RR_EN
      .clk      (clk),
      .resetn   (resetn),
`endif
      .en_i     (pick_en),
      .ic_req_i (ic_rd_req),
      .dc_req_i (dc_rd_req),
      .ic_gnt_o (ic_gnt),
      .dc_gnt_o (dc_gnt)
   );

   assign sel_type  = dc_gnt ? dc_rd_type : ic_rd_type;
   assign sel_addr  = dc_gnt ? dc_rd_addr : ic_rd_addr;
   assign beat_last = (beat_q == len_q);

   always_comb begin
      state_d      = state_q;
      owner_dc_d   = owner_dc_q;
      id_d         = id_q;
      addr_d       = addr_q;
      len_d        = len_q;
      beat_d       = beat_q;
      err_d        = err_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      ic_ret_valid = 1'b0;
      dc_ret_valid = 1'b0;
      ic_ret_last  = 1'b0;
      dc_ret_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ic_gnt | dc_gnt) begin
               owner_dc_d = dc_gnt;
               id_d       = dc_gnt ? DC_ID : IC_ID;
               addr_d     = (sel_type == RD_TYPE_LINE) ? (sel_addr & LINE_MASK) : sel_addr;
               len_d      = (sel_type == RD_TYPE_LINE) ? LINE_LEN : 8'd0;
               state_d    = ST_ADDR;
            end
         end
         ST_ADDR: begin
            arvalid = 1'b1;
            if (arready) begin
               beat_d  = 8'd0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               ic_ret_valid = ~owner_dc_q;
               dc_ret_valid = owner_dc_q;
               ic_ret_last  = ~owner_dc_q & beat_last;
               dc_ret_last  = owner_dc_q & beat_last;
               beat_d       = beat_q + 8'd1;
               // A bad RID or misplaced RLAST is flagged, but the burst length still rules.
               if ((rid != id_q) || (rlast != beat_last)) begin
                  err_d = 1'b1;
               end
               if (beat_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         owner_dc_q <= 1'b0;
         id_q       <= 4'd0;
         addr_q     <= 32'd0;
         len_q      <= 8'd0;
         beat_q     <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_dc_q <= owner_dc_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
      end
   end

   assign ic_rd_rdy   = ic_gnt;
   assign dc_rd_rdy   = dc_gnt;
   assign ic_ret_data = ic_ret_valid ? rdata : 32'd0;
   assign dc_ret_data = dc_ret_valid ? rdata : 32'd0;
   assign arid        = id_q;
   assign araddr      = addr_q;
   assign arlen       = len_q;
   assign arsize      = AXI_SIZE_4B;
   assign arburst     = AXI_BURST_INCR;
   assign rd_err      = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed table, held-request arbitration,
// randomized transactions, protocol-error and mid-burst reset sequences.
module tb_axi_rd_arbiter;

   localparam int unsigned LINE_WORDS = 8;
   localparam logic [3:0]  IC_ID      = 4'd0;
   localparam logic [3:0]  DC_ID      = 4'd1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ic_rd_req, ic_rd_type, ic_rd_rdy, ic_ret_valid, ic_ret_last;
   logic [31:0] ic_rd_addr, ic_ret_data;
   logic        dc_rd_req, dc_rd_type, dc_rd_rdy, dc_ret_valid, dc_ret_last;
   logic [31:0] dc_rd_addr, dc_ret_data;
   logic [3:0]  arid, rid;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, dbg_state;
   logic        arvalid, arready, rlast, rvalid, rready, rd_err;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   bit model_last_dc;

   typedef struct {
      bit          dc;
      bit          typ;
      logic [31:0] addr;
      logic [31:0] exp_araddr;
      logic [7:0]  exp_arlen;
      int          ar_delay;
   } vec_t;
   vec_t vecs[5];

   axi_rd_arbiter #(.LINE_WORDS(LINE_WORDS), .IC_ID(IC_ID), .DC_ID(DC_ID)) dut (
      .clk(clk), .resetn(resetn),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
      .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
      .ic_ret_data(ic_ret_data),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
      .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
      .dc_ret_data(dc_ret_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .rd_err(rd_err), .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit expired");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: cache-line bursts start at the line base, words go out as-is.
   function automatic logic [31:0] model_araddr(input bit typ, input logic [31:0] addr);
      return typ ? (addr - (addr % 32'(LINE_WORDS * 4))) : addr;
   endfunction

   function automatic logic [7:0] model_arlen(input bit typ);
      return typ ? 8'(LINE_WORDS - 1) : 8'd0;
   endfunction

   // Returns 1 when the dcache should win.
   function automatic bit model_pick(input bit ic, input bit dc);
      if (ic && dc) begin
`ifdef AXI_RD_ARB_RR_EN
         return !model_last_dc;
`else
         return 1'b1;
`endif
      end
      return dc;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_arvalid"}, arvalid, 0);
      check({tag, "_rready"}, rready, 0);
      check({tag, "_rdy"}, {ic_rd_rdy, dc_rd_rdy}, 0);
      check({tag, "_ret_valid"}, {ic_ret_valid, dc_ret_valid}, 0);
      check({tag, "_ret_last"}, {ic_ret_last, dc_ret_last}, 0);
      check({tag, "_rd_err"}, rd_err, 0);
      check({tag, "_araddr"}, araddr, 0);
      check({tag, "_arlen"}, arlen, 0);
   endtask

   // One full transaction, starting in the IDLE cycle where the grant is expected.
   task automatic serve(input bit exp_dc, input logic [31:0] ea, input logic [7:0] el,
                        input int ar_delay, input int gap_max, input int bad_last_at,
                        input int bad_rid_at, input int rst_at, input bit drop,
                        input bit scramble);
      logic [3:0] eid;
      int gap;
      eid = exp_dc ? DC_ID : IC_ID;
      #1;
      check("grant_ic", ic_rd_rdy, !exp_dc);
      check("grant_dc", dc_rd_rdy, exp_dc);
      model_last_dc = exp_dc;
      @(negedge clk);
      if (drop) begin
         if (exp_dc) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
      end
      if (scramble) begin
         if (exp_dc) begin dc_rd_addr = $urandom; dc_rd_type = ~dc_rd_type; end
         else begin ic_rd_addr = $urandom; ic_rd_type = ~ic_rd_type; end
      end
      #1;
      check("ar_valid", arvalid, 1);
      check("ar_addr", araddr, ea);
      check("ar_len", arlen, el);
      check("ar_id", arid, eid);
      check("ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
      check("rdy_in_addr", {ic_rd_rdy, dc_rd_rdy}, 0);
      for (int i = 0; i < ar_delay; i++) begin
         @(negedge clk); #1;
         check("ar_hold_valid", arvalid, 1);
         check("ar_hold_addr", araddr, ea);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int b = 0; b <= int'(el); b++) begin
         gap = int'($urandom_range(gap_max, 0));
         for (int g = 0; g < gap; g++) begin
            rvalid = 1'b0;
            #1;
            check("gap_rready", rready, 1);
            check("gap_ret_valid", {ic_ret_valid, dc_ret_valid}, 0);
            @(negedge clk);
         end
         rvalid = 1'b1;
         rid    = (b == bad_rid_at) ? (eid ^ 4'h5) : eid;
         rdata  = $urandom;
         rlast  = (b == int'(el)) || (b == bad_last_at);
         exp_q.push_back(rdata);
         if (b == rst_at) begin
            resetn = 1'b0;
            #1;
            check_all_zero("mid_reset");
            rvalid = 1'b0;
            rlast  = 1'b0;
            exp_q.delete();
            model_last_dc = 1'b1;
            return;
         end
         #1;
         check("beat_owner_valid", exp_dc ? dc_ret_valid : ic_ret_valid, 1);
         check("beat_other_valid", exp_dc ? ic_ret_valid : dc_ret_valid, 0);
         check("beat_data", exp_dc ? dc_ret_data : ic_ret_data, exp_q.pop_front());
         check("beat_last", exp_dc ? dc_ret_last : ic_ret_last, (b == int'(el)));
         @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      #1;
      check("idle_arvalid", arvalid, 0);
      check("idle_rready", rready, 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_last_dc = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      bit w, ic_new, dc_new;
      vecs[0] = '{0, 1, 32'h1fc0_0014, 32'h1fc0_0000, 8'd7, 2};
      vecs[1] = '{1, 0, 32'h1faf_f004, 32'h1faf_f004, 8'd0, 0};
      vecs[2] = '{1, 1, 32'h0000_103c, 32'h0000_1020, 8'd7, 1};
      vecs[3] = '{0, 0, 32'h8000_0002, 32'h8000_0002, 8'd0, 0};
      vecs[4] = '{0, 1, 32'hffff_ffe0, 32'hffff_ffe0, 8'd7, 0};

      // reset with a request pending: nothing may be granted
      resetn = 1'b0; arready = 0; rvalid = 0; rlast = 0; rid = 0; rdata = 0;
      ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
      dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h1234_5678;
      model_last_dc = 1'b1;
      @(negedge clk); #1;
      check_all_zero("reset");
      dc_rd_req = 0;
      @(negedge clk);
      resetn = 1'b1;

      // directed table
      foreach (vecs[i]) begin
         if (vecs[i].dc) begin
            dc_rd_req = 1; dc_rd_type = vecs[i].typ; dc_rd_addr = vecs[i].addr;
         end else begin
            ic_rd_req = 1; ic_rd_type = vecs[i].typ; ic_rd_addr = vecs[i].addr;
         end
         serve(vecs[i].dc, vecs[i].exp_araddr, vecs[i].exp_arlen, vecs[i].ar_delay,
               0, -1, -1, -1, 1'b1, 1'b1);
      end

      // both requests held for four grants, then drained
      ic_rd_req = 1; dc_rd_req = 1; ic_rd_type = 1; dc_rd_type = 1;
      for (int k = 0; k < 4; k++) begin
         ic_rd_addr = 32'h0001_0000 + 32'(k * 64);
         dc_rd_addr = 32'h0002_0004 + 32'(k * 64);
         w = model_pick(1, 1);
         serve(w, model_araddr(1, w ? dc_rd_addr : ic_rd_addr), 8'd7, 0, 0,
               -1, -1, -1, 1'b0, 1'b0);
      end
      while (ic_rd_req || dc_rd_req) begin
         w = model_pick(ic_rd_req, dc_rd_req);
         serve(w, model_araddr(1, w ? dc_rd_addr : ic_rd_addr), 8'd7, 0, 0,
               -1, -1, -1, 1'b1, 1'b0);
      end

      // randomized traffic; a loser keeps its request and address until granted
      for (int n = 0; n < 16; n++) begin
         ic_new = ($urandom_range(1, 0) == 1) && !ic_rd_req;
         dc_new = ($urandom_range(1, 0) == 1) && !dc_rd_req;
         if (!ic_new && !dc_new && !ic_rd_req && !dc_rd_req) dc_new = 1;
         if (ic_new) begin ic_rd_req = 1; ic_rd_type = 1'($urandom); ic_rd_addr = $urandom; end
         if (dc_new) begin dc_rd_req = 1; dc_rd_type = 1'($urandom); dc_rd_addr = $urandom; end
         w = model_pick(ic_rd_req, dc_rd_req);
         serve(w, model_araddr(w ? dc_rd_type : ic_rd_type, w ? dc_rd_addr : ic_rd_addr),
               model_arlen(w ? dc_rd_type : ic_rd_type), int'($urandom_range(3, 0)), 3,
               -1, -1, -1, 1'b1, 1'b0);
      end
      while (ic_rd_req || dc_rd_req) begin
         w = model_pick(ic_rd_req, dc_rd_req);
         serve(w, model_araddr(w ? dc_rd_type : ic_rd_type, w ? dc_rd_addr : ic_rd_addr),
               model_arlen(w ? dc_rd_type : ic_rd_type), 0, 1, -1, -1, -1, 1'b1, 1'b0);
      end
      check("no_err_clean", rd_err, 0);

      // long arready stall with rvalid gaps
      ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h4000_0078;
      serve(0, 32'h4000_0060, 8'd7, 10, 3, -1, -1, -1, 1'b1, 1'b1);
      check("no_err_stall", rd_err, 0);

      // wrong RID on beat 2
      dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h0000_0200;
      serve(1, 32'h0000_0200, 8'd7, 0, 0, -1, 1, -1, 1'b1, 1'b0);
      check("err_rid", rd_err, 1);
      do_reset();
      #1 check("err_cleared", rd_err, 0);

      // early RLAST on beat 5 of 8; burst still runs to beat 8
      ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h1fc0_0014;
      serve(0, 32'h1fc0_0000, 8'd7, 0, 0, 4, -1, -1, 1'b1, 1'b0);
      check("err_rlast", rd_err, 1);
      dc_rd_req = 1; dc_rd_type = 0; dc_rd_addr = 32'h1faf_f004;
      serve(1, 32'h1faf_f004, 8'd0, 0, 0, -1, -1, -1, 1'b1, 1'b0);
      check("err_sticky", rd_err, 1);
      do_reset();

      // reset during beat 3, then a clean grant from IDLE
      ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h0000_5000;
      serve(0, 32'h0000_5000, 8'd7, 0, 0, -1, -1, 2, 1'b0, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      ic_rd_addr = 32'h0000_6010;
      serve(0, 32'h0000_6000, 8'd7, 0, 0, -1, -1, -1, 1'b1, 1'b0);
      check("post_reset_err", rd_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
